// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the unified 8-bit RAM port arbiter.
//  - Load/store opcode codes used by the LSB path.
//  - IO_BASE: first memory-mapped I/O address.
//  - IF_BYTES: bytes per instruction fetch.
//  - Helpers: op_width() gives the byte count of an access, is_store() flags stores.
//  - `True / `False shorthand for single-bit constants.
`ifndef MEM_ARBITER_PKG_DEFINES
`define MEM_ARBITER_PKG_DEFINES
`define True  1'b1
`define False 1'b0
`endif

package mem_arbiter_pkg;

    localparam logic [31:0] IO_BASE  = 32'h0003_0000;
    localparam logic [2:0]  IF_BYTES = 3'd4;

    localparam logic [5:0] OP_LB  = 6'd1;
    localparam logic [5:0] OP_LH  = 6'd2;
    localparam logic [5:0] OP_LW  = 6'd3;
    localparam logic [5:0] OP_LBU = 6'd4;
    localparam logic [5:0] OP_LHU = 6'd5;
    localparam logic [5:0] OP_SB  = 6'd6;
    localparam logic [5:0] OP_SH  = 6'd7;
    localparam logic [5:0] OP_SW  = 6'd8;

    // Unknown codes fall back to a full word.
    function automatic logic [2:0] op_width(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 3'd1;
            OP_LH, OP_LHU, OP_SH: return 3'd2;
            default:              return 3'd4;
        endcase
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Combinational load-result extension.
// Ports:
//  raw     in  32  assembled little-endian bytes (unused upper bytes are zero)
//  opcode  in  6   access opcode (fetches are presented as OP_LW)
//  result  out 32  LB/LH sign-extended, LBU/LHU zero-extended, LW full word,
//                  stores return 0
module mem_load_ext
    import mem_arbiter_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [5:0]  opcode,
    output logic [31:0] result
);

    always_comb begin
        result = raw;
        case (opcode)
            OP_LB:               result = {{24{raw[7]}}, raw[7:0]};
            OP_LH:               result = {{16{raw[15]}}, raw[15:0]};
            OP_LBU:              result = {24'd0, raw[7:0]};
            OP_LHU:              result = {16'd0, raw[15:0]};
            OP_SB, OP_SH, OP_SW: result = 32'd0;
            default:             result = raw;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Sole owner of the 8-bit unified RAM port. Arbitrates instruction fetches
// against LSB load/stores (LSB wins), serialises each access into byte beats,
// assembles and extends load data, and pulses one done per transaction.
// Optional feature: define MEM_IO_STALL_EN to hold I/O stores (addr >= IO_BASE)
// while io_buffer_full is high, both before acceptance and per write beat.
// Ports:
//  clk, rst        clock; asynchronous active-low reset
//  rdy             global enable; low freezes everything and forces mem_wr=0
//  if_req/if_addr  fetch request (held until if_done)
//  if_done/if_rdata one-cycle completion pulse + fetched word
//  lsb_req/lsb_addr/lsb_wdata/lsb_opcode  load/store request (held until lsb_done)
//  lsb_done/lsb_rdata  one-cycle completion pulse + extended load data (0 for stores)
//  mem_din/mem_dout/mem_a/mem_wr  RAM byte port; read data arrives one cycle after address
//  io_buffer_full  I/O sink full (only observed with MEM_IO_STALL_EN)
//  dbg_state       current FSM state
// Handshake: a request is held high from issue until its done pulse; the
// arbiter accepts it at a clock edge in IDLE and ignores requests during DONE,
// so the requester may drop it on the edge after done without a double issue.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_rdata,
    input  logic        lsb_req,
    input  logic [31:0] lsb_addr,
    input  logic [31:0] lsb_wdata,
    input  logic [5:0]  lsb_opcode,
    output logic        lsb_done,
    output logic [31:0] lsb_rdata,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

    state_t      state, next_state;
    logic [2:0]  cnt, len;
    logic [31:0] addr_q, wdata_q, buf_q, ext_data;
    logic [5:0]  op_q;
    logic        owner_lsb;
    logic [31:0] mem_a_q, if_rdata_q, lsb_rdata_q;
    logic [7:0]  mem_dout_q;
    logic        mem_wr_q, if_done_q, lsb_done_q;
    logic        take_lsb, take_if, lsb_blocked, io_stall;
    logic [1:0]  rd_idx, wr_idx;

`ifdef MEM_IO_STALL_EN
    logic is_io;
    assign lsb_blocked = is_store(lsb_opcode) && (lsb_addr >= IO_BASE) && io_buffer_full;
    // Only a beat actually being driven stalls; the trailing idle cycle does not.
    assign io_stall    = (state == S_WRITE) && is_io && io_buffer_full && mem_wr_q;
`else
    logic unused_io;
    assign unused_io   = io_buffer_full;
    assign lsb_blocked = 1'b0;
    assign io_stall    = 1'b0;
`endif

    assign take_lsb = lsb_req && !lsb_blocked;
    assign take_if  = if_req && !take_lsb;

    // Read capture lags the address by one beat; write data leads by one.
    assign rd_idx = 2'(cnt - 3'd1);
    assign wr_idx = 2'(cnt + 3'd1);

    mem_load_ext u_ext (
        .raw    (buf_q),
        .opcode (op_q),
        .result (ext_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)     state <= S_IDLE;
        else if (rdy) state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (take_lsb)     next_state = is_store(lsb_opcode) ? S_WRITE : S_READ;
                else if (take_if) next_state = S_READ;
            end
            S_READ:  if (cnt == len + 3'd1)       next_state = S_DONE;
            S_WRITE: if (!io_stall && cnt == len) next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt         <= '0;
            len         <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            op_q        <= '0;
            owner_lsb   <= `False;
            buf_q       <= '0;
            mem_a_q     <= '0;
            mem_dout_q  <= '0;
            mem_wr_q    <= `False;
            if_done_q   <= `False;
            lsb_done_q  <= `False;
            if_rdata_q  <= '0;
            lsb_rdata_q <= '0;
`ifdef MEM_IO_STALL_EN
            is_io       <= `False;
`endif
        end else if (rdy) begin
            if_done_q  <= `False;
            lsb_done_q <= `False;
            case (state)
                S_IDLE: begin
                    if (take_lsb) begin
                        addr_q    <= lsb_addr;
                        wdata_q   <= lsb_wdata;
                        op_q      <= lsb_opcode;
                        len       <= op_width(lsb_opcode);
                        owner_lsb <= `True;
                        mem_a_q   <= lsb_addr;
                        cnt       <= '0;
                        buf_q     <= '0;
`ifdef MEM_IO_STALL_EN
                        is_io     <= (lsb_addr >= IO_BASE);
`endif
                        if (is_store(lsb_opcode)) begin
                            mem_wr_q   <= `True;
                            mem_dout_q <= lsb_wdata[7:0];
                        end
                    end else if (take_if) begin
                        addr_q    <= if_addr;
                        op_q      <= OP_LW;
                        len       <= IF_BYTES;
                        owner_lsb <= `False;
                        mem_a_q   <= if_addr;
                        cnt       <= '0;
                        buf_q     <= '0;
                    end
                end
                S_READ: begin
                    if (cnt == len + 3'd1) begin
                        if (owner_lsb) begin
                            lsb_done_q  <= `True;
                            lsb_rdata_q <= ext_data;
                        end else begin
                            if_done_q  <= `True;
                            if_rdata_q <= ext_data;
                        end
                    end else begin
                        cnt <= cnt + 3'd1;
                        if (cnt + 3'd1 < len)
                            mem_a_q <= addr_q + 32'(cnt) + 32'd1;
                        if (cnt != 3'd0)
                            buf_q[{rd_idx, 3'b000} +: 8] <= mem_din;
                    end
                end
                S_WRITE: begin
                    if (!io_stall) begin
                        if (cnt == len) begin
                            lsb_done_q  <= `True;
                            lsb_rdata_q <= ext_data;
                        end else begin
                            cnt <= cnt + 3'd1;
                            if (cnt + 3'd1 < len) begin
                                mem_a_q    <= addr_q + 32'(cnt) + 32'd1;
                                mem_dout_q <= wdata_q[{wr_idx, 3'b000} +: 8];
                            end else begin
                                mem_wr_q <= `False;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_wr    = mem_wr_q && rdy && !io_stall;
    assign mem_a     = mem_a_q;
    assign mem_dout  = mem_dout_q;
    assign if_done   = if_done_q;
    assign if_rdata  = if_rdata_q;
    assign lsb_done  = lsb_done_q;
    assign lsb_rdata = lsb_rdata_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: byte RAM model on the memory port, a shadow copy of
// memory used to predict load results, and an expected queue of write beats.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst, rdy, if_req, lsb_req, io_buffer_full;
    logic [31:0] if_addr, lsb_addr, lsb_wdata;
    logic [5:0]  lsb_opcode;
    logic [7:0]  mem_din;
    logic        if_done, lsb_done, mem_wr;
    logic [31:0] if_rdata, lsb_rdata, mem_a;
    logic [7:0]  mem_dout;
    logic [1:0]  dbg_state;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0]  ram    [0:4095];
    logic [7:0]  shadow [0:4095];
    logic [39:0] exp_q[$];
    logic [39:0] mon_exp;

    logic [5:0] ops [8] = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};

    mem_arbiter dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
        .lsb_req(lsb_req), .lsb_addr(lsb_addr), .lsb_wdata(lsb_wdata), .lsb_opcode(lsb_opcode),
        .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // RAM: 4 KiB, addresses alias on the low 12 bits. Read data is registered
    // and shares the global enable, so a frozen system sees the same byte on resume.
    always @(posedge clk) begin
        if (rdy) mem_din <= ram[mem_a[11:0]];
        if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
    end

    // Every write beat must match the next expected (address, byte).
    always @(negedge clk) begin
        if (mem_wr === 1'b1) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL write_beat: unexpected write a=%h d=%h, none required", mem_a, mem_dout);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({mem_a, mem_dout} !== mon_exp) begin
                    tests_failed++;
                    $display("FAIL write_beat: got a=%h d=%h, required a=%h d=%h",
                             mem_a, mem_dout, mon_exp[39:8], mon_exp[7:0]);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int width_of(input logic [5:0] op);
        if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
        if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
        return 4;
    endfunction

    function automatic bit store_op(input logic [5:0] op);
        return op == OP_SB || op == OP_SH || op == OP_SW;
    endfunction

    function automatic logic [31:0] model_load(input logic [5:0] op, input logic [31:0] addr);
        logic [31:0] w;
        logic [31:0] a;
        w = 32'd0;
        for (int k = 0; k < width_of(op); k++) begin
            a = addr + 32'(k);
            w = w + (32'(shadow[a[11:0]]) << (8 * k));
        end
        if (op == OP_LB)  return 32'($signed(w[7:0]));
        if (op == OP_LH)  return 32'($signed(w[15:0]));
        if (op == OP_LBU) return w % 32'd256;
        if (op == OP_LHU) return w % 32'd65536;
        if (store_op(op)) return 32'd0;
        return w;
    endfunction

    task automatic set_byte(input logic [31:0] a, input logic [7:0] d);
        ram[a[11:0]]    = d;
        shadow[a[11:0]] = d;
    endtask

    // One transaction through either port; optionally drop rdy for stall_len
    // cycles starting at cycle stall_at after acceptance.
    task automatic run_txn(input bit fetch, input logic [5:0] op, input logic [31:0] addr,
                           input logic [31:0] wdata, input int stall_at, input int stall_len,
                           input string name);
        logic [31:0] exp_data, got_data, a;
        int          exp_lat, lat, n;
        bit          got;
        n = fetch ? 4 : width_of(op);
        if (!fetch && store_op(op)) begin
            for (int k = 0; k < n; k++) begin
                a = addr + 32'(k);
                exp_q.push_back({a, wdata[8*k +: 8]});
                shadow[a[11:0]] = wdata[8*k +: 8];
            end
            exp_data = 32'd0;
            exp_lat  = n + 1 + stall_len;
        end else begin
            exp_data = model_load(fetch ? OP_LW : op, addr);
            exp_lat  = n + 2 + stall_len;
        end
        if (fetch) begin
            if_req = 1'b1; if_addr = addr;
        end else begin
            lsb_req = 1'b1; lsb_addr = addr; lsb_opcode = op; lsb_wdata = wdata;
        end
        @(posedge clk); #1;
        got = 0; lat = 0; got_data = 32'd0;
        for (int cyc = 1; cyc <= 40 && !got; cyc++) begin
            if (stall_len != 0 && cyc == stall_at) rdy = 1'b0;
            if (stall_len != 0 && cyc == stall_at + stall_len) rdy = 1'b1;
            @(posedge clk); #1;
            if (rdy === 1'b0) begin
                tests_run++;
                if (mem_wr !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL %s_frozen_wr: mem_wr=%b while rdy low, required 0", name, mem_wr);
                end
            end
            if (fetch ? if_done : lsb_done) begin
                got = 1; lat = cyc; got_data = fetch ? if_rdata : lsb_rdata;
            end
        end
        rdy = 1'b1;
        if_req = 1'b0; lsb_req = 1'b0;
        tests_run++;
        if (!got) begin
            tests_failed++;
            $display("FAIL %s_timeout: no done within 40 cycles, required at %0d", name, exp_lat);
        end else begin
            tests_run++;
            if (lat !== exp_lat) begin
                tests_failed++;
                $display("FAIL %s_latency: got %0d, required %0d", name, lat, exp_lat);
            end
            if (got_data !== exp_data) begin
                tests_failed++;
                $display("FAIL %s_data: got %h, required %h", name, got_data, exp_data);
            end
        end
        @(posedge clk); #1;
        tests_run++;
        if (if_done !== 1'b0 || lsb_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_pulse: done still high (if=%b lsb=%b), required 0", name, if_done, lsb_done);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0; rdy = 1'b1; if_req = 1'b0; lsb_req = 1'b0; io_buffer_full = 1'b0;
        if_addr = 32'd0; lsb_addr = 32'd0; lsb_wdata = 32'd0; lsb_opcode = OP_LW;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({if_done, lsb_done, mem_wr} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_flags: if_done/lsb_done/mem_wr=%b, required 000", {if_done, lsb_done, mem_wr});
        end
        tests_run++;
        if ({mem_a, mem_dout, if_rdata, lsb_rdata} !== 104'd0) begin
            tests_failed++;
            $display("FAIL reset_data: mem_a=%h dout=%h if_rdata=%h lsb_rdata=%h, required all 0",
                     mem_a, mem_dout, if_rdata, lsb_rdata);
        end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        set_byte(32'h100, 8'h11); set_byte(32'h101, 8'h22);
        set_byte(32'h102, 8'h33); set_byte(32'h103, 8'h44);
        run_txn(0, OP_LW, 32'h100, 32'd0, 0, 0, "lw_100");
        set_byte(32'h200, 8'h80);
        run_txn(0, OP_LB, 32'h200, 32'd0, 0, 0, "lb_200");
        run_txn(0, OP_LBU, 32'h200, 32'd0, 0, 0, "lbu_200");
        set_byte(32'h210, 8'h34); set_byte(32'h211, 8'hF2);
        run_txn(0, OP_LH, 32'h210, 32'd0, 0, 0, "lh_210");
        run_txn(0, OP_LHU, 32'h210, 32'd0, 0, 0, "lhu_210");
        run_txn(0, OP_SH, 32'h300, 32'hAABBCCDD, 0, 0, "sh_300");
        run_txn(0, OP_LW, 32'h300, 32'd0, 0, 0, "lw_300");
        run_txn(0, OP_SW, 32'hFFFF_FFFE, 32'h1234_5678, 0, 0, "sw_wrap");
        run_txn(1, OP_LW, 32'hFFFF_FFFE, 32'd0, 0, 0, "fetch_wrap");
    endtask

    task automatic test_priority();
        logic [31:0] exp_l, exp_f, d_l, d_f;
        int nl, nf, lat_l, lat_f;
        exp_l = model_load(OP_LW, 32'h400);
        exp_f = model_load(OP_LW, 32'h500);
        nl = 0; nf = 0; lat_l = 0; lat_f = 0; d_l = 0; d_f = 0;
        lsb_req = 1'b1; lsb_addr = 32'h400; lsb_opcode = OP_LW; lsb_wdata = 32'd0;
        if_req = 1'b1; if_addr = 32'h500;
        @(posedge clk); #1;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(posedge clk); #1;
            if (lsb_done) begin nl++; lat_l = cyc; d_l = lsb_rdata; lsb_req = 1'b0; end
            if (if_done)  begin nf++; lat_f = cyc; d_f = if_rdata;  if_req = 1'b0; end
        end
        lsb_req = 1'b0; if_req = 1'b0;
        tests_run++;
        if (nl !== 1 || nf !== 1) begin
            tests_failed++;
            $display("FAIL prio_count: lsb pulses %0d fetch pulses %0d, required 1 and 1", nl, nf);
        end
        tests_run++;
        if (lat_l !== 6 || lat_f !== 14) begin
            tests_failed++;
            $display("FAIL prio_order: lsb at %0d fetch at %0d, required 6 and 14", lat_l, lat_f);
        end
        tests_run++;
        if (d_l !== exp_l || d_f !== exp_f) begin
            tests_failed++;
            $display("FAIL prio_data: lsb %h fetch %h, required %h and %h", d_l, d_f, exp_l, exp_f);
        end
    endtask

    task automatic test_rdy_stall();
        run_txn(0, OP_LW, 32'h120, 32'd0, 2, 3, "lw_rdy");
        run_txn(0, OP_SW, 32'h130, 32'hCAFE_F00D, 2, 3, "sw_rdy");
        run_txn(1, OP_LW, 32'h130, 32'd0, 4, 2, "fetch_rdy");
    endtask

    task automatic test_reset_mid();
        int ndone;
        if_req = 1'b1; if_addr = 32'h600;
        @(posedge clk); #1;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b0; if_req = 1'b0;
        #1;
        tests_run++;
        if (if_done !== 1'b0 || mem_a !== 32'd0 || mem_wr !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_clear: if_done=%b mem_a=%h mem_wr=%b, required 0 0 0", if_done, mem_a, mem_wr);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        ndone = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (if_done || lsb_done) ndone++;
        end
        tests_run++;
        if (ndone !== 0) begin
            tests_failed++;
            $display("FAIL rst_mid_nodone: %0d done pulses after reset, required 0", ndone);
        end
        run_txn(1, OP_LW, 32'h600, 32'd0, 0, 0, "fetch_after_rst");
    endtask

    task automatic test_io();
`ifdef MEM_IO_STALL_EN
        int nwr;
        bit got;
        io_buffer_full = 1'b1;
        exp_q.push_back({32'h0003_0000, 8'h5A});
        shadow[12'h000] = 8'h5A;
        lsb_req = 1'b1; lsb_addr = 32'h0003_0000; lsb_opcode = OP_SB; lsb_wdata = 32'h0000_005A;
        nwr = 0; got = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (mem_wr || lsb_done) nwr++;
        end
        tests_run++;
        if (nwr !== 0) begin
            tests_failed++;
            $display("FAIL io_hold: %0d write/done cycles while full, required 0", nwr);
        end
        io_buffer_full = 1'b0;
        for (int cyc = 0; cyc < 20 && !got; cyc++) begin
            @(posedge clk); #1;
            if (lsb_done) got = 1;
        end
        lsb_req = 1'b0;
        tests_run++;
        if (!got) begin
            tests_failed++;
            $display("FAIL io_release: no lsb_done after full dropped, required 1");
        end
        @(posedge clk); #1;
`else
        io_buffer_full = 1'b1;
        run_txn(0, OP_SB, 32'h0003_0000, 32'h0000_005A, 0, 0, "io_sb_nostall");
        io_buffer_full = 1'b0;
`endif
        run_txn(0, OP_LBU, 32'h0003_0000, 32'd0, 0, 0, "io_readback");
    endtask

    task automatic test_random();
        logic [31:0] addr, wdata;
        logic [5:0]  op;
        int          kind;
        for (int i = 0; i < 40; i++) begin
            kind  = $urandom_range(0, 8);
            op    = (kind == 8) ? OP_LW : ops[kind];
            addr  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFD : 32'($urandom_range(0, 4095));
            wdata = $urandom;
            run_txn(kind == 8, op, addr, wdata, 0, 0, "rand");
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) set_byte(32'(i), 8'($urandom_range(0, 255)));
        test_reset();
        test_directed();
        test_priority();
        test_rdy_stall();
        test_reset_mid();
        test_io();
        test_random();
        repeat (2) @(posedge clk);
        tests_run++;
        if (exp_q.size() !== 0) begin
            tests_failed++;
            $display("FAIL beats_left: %0d write beats never seen, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
